// File: rtl/rx_comma_align_if.sv
// ============================================================================
// Module   : rx_comma_align_if
// Purpose  : Serial-in / aligned-word-out bundle of the receive comma aligner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_comma_align_if;
   logic       data_in;
   logic       RXPOL;
   logic [9:0] data_out;
   logic       data_valid;
   logic       is_comma;
   logic       sync_ok;
   logic       align_err;

   modport master (
      output data_in,
      output RXPOL,
      input  data_out,
      input  data_valid,
      input  is_comma,
      input  sync_ok,
      input  align_err
   );

   modport slave (
      input  data_in,
      input  RXPOL,
      output data_out,
      output data_valid,
      output is_comma,
      output sync_ok,
      output align_err
   );
endinterface

`default_nettype wire

// File: rtl/rx_comma_align.sv
// ============================================================================
// Module   : rx_comma_align
// Purpose  : Recovers 10-bit word boundaries from K28.5 commas in an LSB-first
//            serial stream, with a LOSS/CHECK/SYNC link qualification machine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_comma_align #(
   parameter int COMMA_CNT = 3,
   parameter int MAX_ERR   = 4
) (
   input  logic            CRC_CKL,
   input  logic            RESET_L,
   rx_comma_align_if.slave link
);

   localparam logic [9:0] C_K28P5_NEG = 10'h17C;
   localparam logic [9:0] C_K28P5_POS = 10'h283;
   localparam logic [3:0] C_COMMA_CNT = 4'(COMMA_CNT);
   localparam logic [3:0] C_MAX_ERR   = 4'(MAX_ERR);
   localparam logic [3:0] C_LAST_BIT  = 4'd9;
   localparam logic [3:0] C_CNT_MAX   = 4'hF;

   typedef enum logic [1:0] {
      ST_LOSS  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SYNC  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_sr;
   logic [9:0] w_sr_nxt;
   logic [3:0] r_phase;
   logic [3:0] w_phase_nxt;
   logic [3:0] r_good;
   logic [3:0] w_good_nxt;
   logic [3:0] w_good_inc;
   logic [3:0] r_err;
   logic [3:0] w_err_nxt;
   logic [3:0] w_err_inc;
   logic       w_bit;
   logic       w_comma;
   logic       w_aligned;
   logic       w_emit;
   logic       w_align_err;

   assign w_bit      = link.data_in ^ link.RXPOL;
   assign w_sr_nxt   = {w_bit, r_sr[9:1]};
   assign w_comma    = (w_sr_nxt == C_K28P5_NEG) || (w_sr_nxt == C_K28P5_POS);
   assign w_aligned  = (r_phase == C_LAST_BIT);
   assign w_good_inc = (r_good == C_CNT_MAX) ? r_good : r_good + 4'd1;
   assign w_err_inc  = (r_err == C_CNT_MAX) ? r_err : r_err + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err_nxt   = r_err;
      w_emit      = 1'b0;
      w_align_err = 1'b0;

      case (r_state)
         ST_LOSS: begin
            if (w_comma) begin
               w_emit      = 1'b1;
               w_good_nxt  = 4'd1;
               w_err_nxt   = 4'd0;
               w_state_nxt = (C_COMMA_CNT <= 4'd1) ? ST_SYNC : ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_comma) begin
               w_emit = 1'b1;
               if (w_aligned) begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc >= C_COMMA_CNT) begin
                     w_state_nxt = ST_SYNC;
                     w_err_nxt   = 4'd0;
                  end
               end else begin
                  // Misplaced comma restarts qualification at the new boundary
                  w_good_nxt = 4'd1;
               end
            end else if (w_aligned) begin
               w_emit = 1'b1;
            end
         end
         ST_SYNC: begin
            if (w_aligned) begin
               w_emit = 1'b1;
               if (w_comma) begin
                  w_err_nxt = 4'd0;
               end
            end else if (w_comma) begin
               w_align_err = 1'b1;
               w_err_nxt   = w_err_inc;
               if (w_err_inc >= C_MAX_ERR) begin
                  w_state_nxt = ST_LOSS;
                  w_good_nxt  = 4'd0;
                  w_err_nxt   = 4'd0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_LOSS;
         end
      endcase

      if (w_emit || w_aligned) begin
         w_phase_nxt = 4'd0;
      end else begin
         w_phase_nxt = r_phase + 4'd1;
      end
   end

   always_ff @(posedge CRC_CKL or negedge RESET_L) begin
      if (!RESET_L) begin
         r_state         <= ST_LOSS;
         r_sr            <= 10'd0;
         r_phase         <= 4'd0;
         r_good          <= 4'd0;
         r_err           <= 4'd0;
         link.data_out   <= 10'd0;
         link.data_valid <= 1'b0;
         link.is_comma   <= 1'b0;
         link.sync_ok    <= 1'b0;
         link.align_err  <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_sr            <= w_sr_nxt;
         r_phase         <= w_phase_nxt;
         r_good          <= w_good_nxt;
         r_err           <= w_err_nxt;
         link.data_valid <= w_emit;
         link.sync_ok    <= (w_state_nxt == ST_SYNC);
         link.align_err  <= w_align_err;
         if (w_emit) begin
            link.data_out <= w_sr_nxt;
            link.is_comma <= w_comma;
         end
      end
   end

endmodule

`default_nettype wire
